// File: rtl/dds_sweep_ctrl_pkg.sv
// Shared types and constants for the DDS frequency-sweep controller.
package dds_sweep_ctrl_pkg;

    localparam int FTW_W       = 32;
    localparam int DWELL_W_DEF = 24;
    localparam int ROMAD_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAST = 2'd2
    } state_t;

    // Sweep parameters captured at start; held for the whole sweep.
    typedef struct packed {
        logic [FTW_W-1:0] f_start;
        logic [FTW_W-1:0] f_stop;
        logic [FTW_W-1:0] f_step;
        logic             cont;
        logic             down;
        logic             degen;
    } sweep_cfg_t;

    // A sweep with no distance to cover or no step size sits on F_START only.
    function automatic logic is_degenerate(input logic [FTW_W-1:0] fs,
                                           input logic [FTW_W-1:0] fe,
                                           input logic [FTW_W-1:0] st);
        return (fs == fe) || (st == '0);
    endfunction

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Command/status bundle between the sweep host and the sweep controller.
interface dds_sweep_ctrl_if
    import dds_sweep_ctrl_pkg::*;
#(
    parameter int ROMAD_WIDTH = ROMAD_W_DEF,
    parameter int DWELL_WIDTH = DWELL_W_DEF
);
    logic                   start;
    logic                   stop;
    logic                   cont;
    logic [FTW_W-1:0]       f_start;
    logic [FTW_W-1:0]       f_stop;
    logic [FTW_W-1:0]       f_step;
    logic [DWELL_WIDTH-1:0] dwell;
    logic [ROMAD_WIDTH-1:0] phase_in;
    logic [FTW_W-1:0]       freqw;
    logic [ROMAD_WIDTH-1:0] phasew;
    logic                   busy;
    logic                   sync;
    logic                   done;

    modport master (
        output start, stop, cont, f_start, f_stop, f_step, dwell, phase_in,
        input  freqw, phasew, busy, sync, done
    );

    modport slave (
        input  start, stop, cont, f_start, f_stop, f_step, dwell, phase_in,
        output freqw, phasew, busy, sync, done
    );
endinterface

// File: rtl/dds_sweep_step.sv
// Next tuning word for one sweep step, clamped to the stop word on overshoot or wrap.
module dds_sweep_step
    import dds_sweep_ctrl_pkg::*;
(
    input  logic [FTW_W-1:0] cur,
    input  logic [FTW_W-1:0] step,
    input  logic [FTW_W-1:0] stop,
    input  logic             down,
    output logic [FTW_W-1:0] nxt,
    output logic             last
);
    logic [FTW_W:0] sum;
    logic [FTW_W:0] diff;

    always_comb begin
        sum  = {1'b0, cur} + {1'b0, step};
        diff = {1'b0, cur} - {1'b0, step};
        last = 1'b0;
        nxt  = sum[FTW_W-1:0];
        // Bit FTW_W is the carry (up) or borrow (down); either means we passed the end.
        if (down) begin
            last = diff[FTW_W] || (diff[FTW_W-1:0] <= stop);
            nxt  = diff[FTW_W-1:0];
        end else begin
            last = sum[FTW_W] || (sum[FTW_W-1:0] >= stop);
        end
        if (last)
            nxt = stop;
    end
endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep controller feeding FREQW/PHASEW of the DDS core.
module dds_sweep_ctrl
    import dds_sweep_ctrl_pkg::*;
#(
    parameter int ROMAD_WIDTH = ROMAD_W_DEF,
    parameter int DWELL_WIDTH = DWELL_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    dds_sweep_ctrl_if.slave  bus
);
    state_t                 state;
    sweep_cfg_t             cfg;
    logic [DWELL_WIDTH-1:0] dwell_r;
    logic [DWELL_WIDTH-1:0] cnt;
    logic [FTW_W-1:0]       freqw_q;
    logic [ROMAD_WIDTH-1:0] phasew_q;
    logic                   busy_q;
    logic                   sync_q;
    logic                   done_q;
    logic [FTW_W-1:0]       nxt;
    logic                   last;

    dds_sweep_step u_step (
        .cur  (freqw_q),
        .step (cfg.f_step),
        .stop (cfg.f_stop),
        .down (cfg.down),
        .nxt  (nxt),
        .last (last)
    );

    assign bus.freqw  = freqw_q;
    assign bus.phasew = phasew_q;
    assign bus.busy   = busy_q;
    assign bus.sync   = sync_q;
    assign bus.done   = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cfg      <= '0;
            dwell_r  <= '0;
            cnt      <= '0;
            freqw_q  <= '0;
            phasew_q <= '0;
            busy_q   <= 1'b0;
            sync_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            sync_q <= 1'b0;
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        cfg <= '{f_start: bus.f_start,
                                 f_stop:  bus.f_stop,
                                 f_step:  bus.f_step,
                                 cont:    bus.cont,
                                 down:    (bus.f_stop < bus.f_start),
                                 degen:   is_degenerate(bus.f_start, bus.f_stop, bus.f_step)};
                        dwell_r  <= bus.dwell;
                        cnt      <= bus.dwell;
                        freqw_q  <= bus.f_start;
                        phasew_q <= bus.phase_in;
                        sync_q   <= 1'b1;
                        busy_q   <= 1'b1;
                        state    <= is_degenerate(bus.f_start, bus.f_stop, bus.f_step)
                                    ? ST_LAST : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        freqw_q <= nxt;
                        cnt     <= dwell_r;
                        if (last)
                            state <= ST_LAST;
                    end
                end
                ST_LAST: begin
                    if (bus.stop) begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (cfg.cont) begin
                        // Wrap back to the start word without leaving BUSY.
                        freqw_q <= cfg.f_start;
                        cnt     <= dwell_r;
                        sync_q  <= 1'b1;
                        state   <= cfg.degen ? ST_LAST : ST_RUN;
                    end else begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: per-cycle FREQW/PHASEW/flag checks against hand point lists.
module tb_dds_sweep_ctrl;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    logic [31:0] exp_pts[$];

    dds_sweep_ctrl_if #(.ROMAD_WIDTH(8), .DWELL_WIDTH(24)) bus ();

    dds_sweep_ctrl #(.ROMAD_WIDTH(8), .DWELL_WIDTH(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a sweep, scrambles the inputs to prove they were latched, then checks
    // every cycle of `periods` passes over exp_pts. Single-shot also checks DONE.
    task automatic run_sweep(input string tag, input logic [31:0] fs, input logic [31:0] fe,
                             input logic [31:0] st, input logic [23:0] dw,
                             input logic cont, input logic [7:0] ph, input int periods);
        bus.f_start = fs; bus.f_stop = fe; bus.f_step = st; bus.dwell = dw;
        bus.cont = cont; bus.phase_in = ph; bus.start = 1'b1; bus.stop = 1'b0;
        tick();
        bus.start = 1'b0;
        bus.f_start = 32'h1234; bus.f_stop = 32'h0; bus.f_step = 32'h1;
        bus.dwell = 24'd7; bus.cont = ~cont; bus.phase_in = ~ph;
        for (int p = 0; p < periods; p++)
            for (int i = 0; i < exp_pts.size(); i++)
                for (int c = 0; c <= int'(dw); c++) begin
                    chk({tag, "_fw"}, 64'(bus.freqw), 64'(exp_pts[i]));
                    chk({tag, "_ph"}, 64'(bus.phasew), 64'(ph));
                    chk({tag, "_bsd"}, 64'({bus.busy, bus.sync, bus.done}),
                        64'({1'b1, (i == 0 && c == 0), 1'b0}));
                    tick();
                end
        if (!cont) begin
            chk({tag, "_fw_end"}, 64'(bus.freqw), 64'(exp_pts[exp_pts.size()-1]));
            chk({tag, "_bsd_end"}, 64'({bus.busy, bus.sync, bus.done}), 64'(3'b001));
            tick();
            chk({tag, "_bsd_idle"}, 64'({bus.busy, bus.sync, bus.done}), 64'(3'b000));
        end
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.cont = 1'b0;
        bus.f_start = '0; bus.f_stop = '0; bus.f_step = '0; bus.dwell = '0; bus.phase_in = '0;
        rst_n = 1'b0;
        #22;
        chk("rst_fw", 64'(bus.freqw), 64'd0);
        chk("rst_ph", 64'(bus.phasew), 64'd0);
        chk("rst_bsd", 64'({bus.busy, bus.sync, bus.done}), 64'd0);
        rst_n = 1'b1;
        tick();

        exp_pts = {32'd100, 32'd110, 32'd120, 32'd130};
        run_sweep("up", 32'd100, 32'd130, 32'd10, 24'd2, 1'b0, 8'h5A, 1);

        exp_pts = {32'd130, 32'd110, 32'd100};
        run_sweep("down", 32'd130, 32'd100, 32'd20, 24'd0, 1'b0, 8'h11, 1);

        exp_pts = {32'hFFFF_FFF0, 32'hFFFF_FFFF};
        run_sweep("ovf", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 24'd0, 1'b0, 8'h22, 1);

        exp_pts = {32'd50};
        run_sweep("step0", 32'd50, 32'd60, 32'd0, 24'd4, 1'b0, 8'h33, 1);

        exp_pts = {32'd70};
        run_sweep("eq", 32'd70, 32'd70, 32'd5, 24'd4, 1'b0, 8'h44, 1);

        // Continuous: two full passes, third pass starts with SYNC, then abort on 110.
        exp_pts = {32'd100, 32'd110, 32'd120, 32'd130};
        run_sweep("cont", 32'd100, 32'd130, 32'd10, 24'd2, 1'b1, 8'h66, 2);
        chk("cont_p3_fw", 64'(bus.freqw), 64'd100);
        chk("cont_p3_bsd", 64'({bus.busy, bus.sync, bus.done}), 64'(3'b110));
        repeat (4) tick();
        chk("cont_p3_fw110", 64'(bus.freqw), 64'd110);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("stop_fw", 64'(bus.freqw), 64'd110);
        chk("stop_bsd", 64'({bus.busy, bus.sync, bus.done}), 64'(3'b000));
        tick();
        chk("stop_fw2", 64'(bus.freqw), 64'd110);
        chk("stop_bsd2", 64'({bus.busy, bus.sync, bus.done}), 64'(3'b000));

        // Asynchronous reset in the middle of an up sweep.
        bus.f_start = 32'd100; bus.f_stop = 32'd130; bus.f_step = 32'd10;
        bus.dwell = 24'd2; bus.cont = 1'b0; bus.phase_in = 8'h77; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        chk("pre_rst_fw", 64'(bus.freqw), 64'd110);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_fw", 64'(bus.freqw), 64'd0);
        chk("arst_ph", 64'(bus.phasew), 64'd0);
        chk("arst_bsd", 64'({bus.busy, bus.sync, bus.done}), 64'd0);
        #2 rst_n = 1'b1;
        tick();

        exp_pts = {32'd130, 32'd110, 32'd100};
        run_sweep("post_rst", 32'd130, 32'd100, 32'd20, 24'd1, 1'b0, 8'h88, 1);

        // START with STOP in IDLE must not start a sweep.
        bus.f_start = 32'd500; bus.f_stop = 32'd600; bus.f_step = 32'd1;
        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        chk("ss_fw", 64'(bus.freqw), 64'd100);
        chk("ss_bsd", 64'({bus.busy, bus.sync, bus.done}), 64'd0);
        tick();
        chk("ss_bsd2", 64'({bus.busy, bus.sync, bus.done}), 64'd0);
        bus.start = 1'b0; bus.stop = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
